// File: rtl/sb_msg_arbiter_pkg.sv
// Shared types and constants for the sideband message arbiter.
package sb_msg_arbiter_pkg;

   localparam int MSG_NO_W   = 4;
   localparam int MSG_INFO_W = 3;
   localparam int DATA_W     = 16;
   localparam int RDI_CODE_W = 2;
   localparam int RDI_SUB_W  = 4;
   localparam int RDI_INFO_W = 2;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_PAT  = 2'd1;
   localparam logic [1:0] GNT_LTSM = 2'd2;
   localparam logic [1:0] GNT_RDI  = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                  pattern_req;
      logic                  msg_valid;
      logic                  rdi_msg;
      logic                  data_valid;
      logic [MSG_NO_W-1:0]   msg_no;
      logic [MSG_INFO_W-1:0] msg_info;
      logic [DATA_W-1:0]     data;
      logic [RDI_CODE_W-1:0] rdi_code;
      logic [RDI_SUB_W-1:0]  rdi_sub_code;
      logic [RDI_INFO_W-1:0] rdi_info;
   } tx_t;

endpackage

// File: rtl/sb_msg_arbiter_rr_sel.sv
// Two-way round-robin picker: bit 0 is LTSM, bit 1 is RDI; the last winner loses the next tie.
module sb_rr_sel (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] win
);

   logic rdi_first;

   // Tie break by pointer, single requests pass straight through.
   always_comb begin
      win = 2'b00;
      if (req == 2'b11) begin
         win = rdi_first ? 2'b10 : 2'b01;
      end else begin
         win = req;
      end
   end

   // Pointer moves only when a message request is actually granted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdi_first <= 1'b0;
      end else if (take && win[0]) begin
         rdi_first <= 1'b1;
      end else if (take && win[1]) begin
         rdi_first <= 1'b0;
      end else begin
         rdi_first <= rdi_first;
      end
   end

endmodule

// File: rtl/sb_msg_arbiter.sv
// Arbitrates pattern, LTSM and RDI requests onto the sideband TX path.
// Define SB_ARB_TIMEOUT_EN to add the per-transfer abort counter.
module sb_msg_arbiter
   import sb_msg_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 800000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_pat_req,
   output logic        o_pat_ack,
   input  logic        i_ltsm_req,
   input  logic [3:0]  i_ltsm_msg_no,
   input  logic [2:0]  i_ltsm_msg_info,
   input  logic [15:0] i_ltsm_data,
   input  logic        i_ltsm_data_valid,
   output logic        o_ltsm_ack,
   input  logic        i_rdi_req,
   input  logic [1:0]  i_rdi_code,
   input  logic [3:0]  i_rdi_sub_code,
   input  logic [1:0]  i_rdi_info,
   output logic        o_rdi_ack,
   input  logic        i_tx_busy,
   output logic        o_tx_pattern_req,
   output logic        o_tx_msg_valid,
   output logic        o_tx_rdi_msg,
   output logic        o_tx_data_valid,
   output logic [3:0]  o_tx_msg_no,
   output logic [2:0]  o_tx_msg_info,
   output logic [15:0] o_tx_data,
   output logic [1:0]  o_tx_rdi_code,
   output logic [3:0]  o_tx_rdi_sub_code,
   output logic [1:0]  o_tx_rdi_info,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("sb_msg_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_t state;
   tx_t        tx;
   tx_t        sel_tx;
   logic [1:0] sel_gnt;
   logic       pat_eff;
   logic [1:0] msg_req;
   logic [1:0] rr_win;
   logic       rr_take;
   logic       timeout_hit;

   // A requester is ignored during its own ack cycle so a held req is not re-granted.
   always_comb begin
      pat_eff = i_pat_req & ~o_pat_ack;
      msg_req = {i_rdi_req & ~o_rdi_ack, i_ltsm_req & ~o_ltsm_ack};
      rr_take = (state == IDLE) && !pat_eff;
   end

   sb_rr_sel u_rr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .req   (msg_req),
      .take  (rr_take),
      .win   (rr_win)
   );

   // Candidate grant and payload; only loaded into the registers from IDLE.
   always_comb begin
      sel_tx  = '0;
      sel_gnt = GNT_NONE;
      if (pat_eff) begin
         sel_tx.pattern_req = 1'b1;
         sel_gnt            = GNT_PAT;
      end else if (rr_win[0]) begin
         sel_tx.msg_valid  = 1'b1;
         sel_tx.data_valid = i_ltsm_data_valid;
         sel_tx.msg_no     = i_ltsm_msg_no;
         sel_tx.msg_info   = i_ltsm_msg_info;
         sel_tx.data       = i_ltsm_data;
         sel_gnt           = GNT_LTSM;
      end else if (rr_win[1]) begin
         sel_tx.msg_valid    = 1'b1;
         sel_tx.rdi_msg      = 1'b1;
         sel_tx.rdi_code     = i_rdi_code;
         sel_tx.rdi_sub_code = i_rdi_sub_code;
         sel_tx.rdi_info     = i_rdi_info;
         sel_gnt             = GNT_RDI;
      end else begin
         sel_tx  = '0;
         sel_gnt = GNT_NONE;
      end
   end

`ifdef SB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_pulse;

   assign timeout_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign o_timeout   = tmo_pulse;

   // Held at zero in IDLE, so it starts from zero on every ISSUE entry.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tmo_cnt   <= '0;
         tmo_pulse <= 1'b0;
      end else begin
         tmo_pulse <= timeout_hit;
         if ((state == IDLE) || timeout_hit) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   // Transfer FSM: grant, hand off to TX, then ack the owner when TX goes idle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         tx         <= '0;
         o_grant    <= GNT_NONE;
         o_pat_ack  <= 1'b0;
         o_ltsm_ack <= 1'b0;
         o_rdi_ack  <= 1'b0;
      end else begin
         o_pat_ack  <= 1'b0;
         o_ltsm_ack <= 1'b0;
         o_rdi_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_gnt != GNT_NONE) begin
                  tx      <= sel_tx;
                  o_grant <= sel_gnt;
                  state   <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (timeout_hit) begin
                  tx      <= '0;
                  o_grant <= GNT_NONE;
                  state   <= IDLE;
               end else if (i_tx_busy) begin
                  tx.pattern_req <= 1'b0;
                  tx.msg_valid   <= 1'b0;
                  state          <= WAIT_DONE;
               end else begin
                  state <= ISSUE;
               end
            end
            WAIT_DONE: begin
               if (timeout_hit) begin
                  tx      <= '0;
                  o_grant <= GNT_NONE;
                  state   <= IDLE;
               end else if (!i_tx_busy) begin
                  o_pat_ack  <= (o_grant == GNT_PAT);
                  o_ltsm_ack <= (o_grant == GNT_LTSM);
                  o_rdi_ack  <= (o_grant == GNT_RDI);
                  tx         <= '0;
                  o_grant    <= GNT_NONE;
                  state      <= IDLE;
               end else begin
                  state <= WAIT_DONE;
               end
            end
            default: begin
               tx      <= '0;
               o_grant <= GNT_NONE;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign o_tx_pattern_req  = tx.pattern_req;
   assign o_tx_msg_valid    = tx.msg_valid;
   assign o_tx_rdi_msg      = tx.rdi_msg;
   assign o_tx_data_valid   = tx.data_valid;
   assign o_tx_msg_no       = tx.msg_no;
   assign o_tx_msg_info     = tx.msg_info;
   assign o_tx_data         = tx.data;
   assign o_tx_rdi_code     = tx.rdi_code;
   assign o_tx_rdi_sub_code = tx.rdi_sub_code;
   assign o_tx_rdi_info     = tx.rdi_info;

endmodule

// File: tb/tb_sb_msg_arbiter.sv
// Self-checking bench for sb_msg_arbiter: directed table, corner sequences, random vs. transaction model.
`timescale 1ns/1ps
module tb_sb_msg_arbiter;

   localparam int TMO = 16;
`ifdef SB_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, pat_req, ltsm_req, ltsm_dv, rdi_req, tx_busy;
   logic [3:0]  ltsm_msg_no, rdi_sub;
   logic [2:0]  ltsm_msg_info;
   logic [15:0] ltsm_data;
   logic [1:0]  rdi_code, rdi_info;

   logic        o_pat_ack, o_ltsm_ack, o_rdi_ack, o_timeout;
   logic        o_tx_pattern_req, o_tx_msg_valid, o_tx_rdi_msg, o_tx_data_valid;
   logic [3:0]  o_tx_msg_no, o_tx_rdi_sub_code;
   logic [2:0]  o_tx_msg_info;
   logic [15:0] o_tx_data;
   logic [1:0]  o_tx_rdi_code, o_tx_rdi_info, o_grant;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sb_msg_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_pat_req(pat_req), .o_pat_ack(o_pat_ack),
      .i_ltsm_req(ltsm_req), .i_ltsm_msg_no(ltsm_msg_no), .i_ltsm_msg_info(ltsm_msg_info),
      .i_ltsm_data(ltsm_data), .i_ltsm_data_valid(ltsm_dv), .o_ltsm_ack(o_ltsm_ack),
      .i_rdi_req(rdi_req), .i_rdi_code(rdi_code), .i_rdi_sub_code(rdi_sub),
      .i_rdi_info(rdi_info), .o_rdi_ack(o_rdi_ack),
      .i_tx_busy(tx_busy),
      .o_tx_pattern_req(o_tx_pattern_req), .o_tx_msg_valid(o_tx_msg_valid),
      .o_tx_rdi_msg(o_tx_rdi_msg), .o_tx_data_valid(o_tx_data_valid),
      .o_tx_msg_no(o_tx_msg_no), .o_tx_msg_info(o_tx_msg_info), .o_tx_data(o_tx_data),
      .o_tx_rdi_code(o_tx_rdi_code), .o_tx_rdi_sub_code(o_tx_rdi_sub_code),
      .o_tx_rdi_info(o_tx_rdi_info), .o_grant(o_grant), .o_timeout(o_timeout)
   );

   logic [40:0] all_out;
   logic [10:0] ctl_obs;
   assign all_out = {o_grant, o_timeout, o_pat_ack, o_ltsm_ack, o_rdi_ack, o_tx_pattern_req,
                     o_tx_msg_valid, o_tx_rdi_msg, o_tx_data_valid, o_tx_msg_no, o_tx_msg_info,
                     o_tx_data, o_tx_rdi_code, o_tx_rdi_sub_code, o_tx_rdi_info};
   assign ctl_obs = {o_grant, o_tx_pattern_req, o_tx_msg_valid, o_tx_rdi_msg, o_tx_data_valid,
                     o_pat_ack, o_ltsm_ack, o_rdi_ack, o_timeout};

   typedef struct packed {
      logic p, l, r, busy;
      logic [1:0] g;
      logic [2:0] ack;   // {pat, ltsm, rdi}
      logic iss;         // pattern_req | msg_valid
   } vec_t;
   vec_t tbl [11];

   // transaction-level reference: who owns the TX path and whether it was handed off
   int   m_owner, m_last, m_ack, m_age;
   bit   m_sent, m_tmo, m_dv;
   logic [22:0] m_ltsm;
   logic [7:0]  m_rdi;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      pat_req = 1'b0; ltsm_req = 1'b0; ltsm_dv = 1'b0; rdi_req = 1'b0; tx_busy = 1'b0;
      ltsm_msg_no = 4'h0; ltsm_msg_info = 3'h0; ltsm_data = 16'h0;
      rdi_code = 2'h0; rdi_sub = 4'h0; rdi_info = 2'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic model_edge();
      int prev;
      bit wp, wl, wr;
      prev  = m_ack;
      m_ack = 0;
      m_tmo = 1'b0;
      if (m_owner == 0) begin
         wp = pat_req  && (prev != 1);
         wl = ltsm_req && (prev != 2);
         wr = rdi_req  && (prev != 3);
         if (wp) m_owner = 1;
         else if (wl && wr) m_owner = (m_last == 2) ? 3 : 2;
         else if (wl) m_owner = 2;
         else if (wr) m_owner = 3;
         if (m_owner >= 2) m_last = m_owner;
         if (m_owner != 0) begin
            m_sent = 1'b0;
            m_age  = 0;
            m_dv   = ltsm_dv;
            m_ltsm = {ltsm_msg_no, ltsm_msg_info, ltsm_data};
            m_rdi  = {rdi_code, rdi_sub, rdi_info};
         end
      end else if (TMO_EN && (m_age == TMO - 1)) begin
         m_tmo   = 1'b1;
         m_owner = 0;
      end else begin
         m_age++;
         if (!m_sent) begin
            m_sent = tx_busy;
         end else if (!tx_busy) begin
            m_ack   = m_owner;
            m_owner = 0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, nerr;
      logic [10:0] ctl_exp;

      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'b000, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3'b100, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'b000, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 3'b000, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'b010, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 3'b000, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 3'b000, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};

      // reset with requests active: everything stays at zero
      clear_inputs();
      rst_n = 1'b0;
      pat_req = 1'b1; ltsm_req = 1'b1; rdi_req = 1'b1;
      tick();
      check("reset_outputs", 64'(all_out), 64'd0);

      // simultaneous requests: pattern, then LTSM, then RDI
      do_reset();
      for (int i = 0; i < 11; i++) begin
         pat_req = tbl[i].p; ltsm_req = tbl[i].l; rdi_req = tbl[i].r; tx_busy = tbl[i].busy;
         tick();
         check($sformatf("tbl_grant[%0d]", i), 64'(o_grant), 64'(tbl[i].g));
         check($sformatf("tbl_ack[%0d]", i), 64'({o_pat_ack, o_ltsm_ack, o_rdi_ack}), 64'(tbl[i].ack));
         check($sformatf("tbl_issue[%0d]", i), 64'(o_tx_pattern_req | o_tx_msg_valid), 64'(tbl[i].iss));
      end

      // single LTSM transfer with payload, busy high after 3 cycles for 10 cycles
      do_reset();
      ltsm_req = 1'b1; ltsm_msg_no = 4'h5; ltsm_msg_info = 3'h2; ltsm_data = 16'hA5A5; ltsm_dv = 1'b1;
      tick();
      check("ltsm_grant", 64'(o_grant), 64'd2);
      check("ltsm_payload", 64'({o_tx_msg_valid, o_tx_data_valid, o_tx_rdi_msg, o_tx_msg_no, o_tx_msg_info, o_tx_data}),
            64'({1'b1, 1'b1, 1'b0, 4'h5, 3'h2, 16'hA5A5}));
      ltsm_msg_no = 4'hC; ltsm_data = 16'h0000; ltsm_dv = 1'b0;
      tick();
      tick();
      check("ltsm_valid_held", 64'({o_tx_msg_valid, o_tx_msg_no, o_tx_data}), 64'({1'b1, 4'h5, 16'hA5A5}));
      tx_busy = 1'b1;
      tick();
      check("ltsm_handoff", 64'({o_grant, o_tx_msg_valid, o_tx_data_valid}), 64'({2'd2, 1'b0, 1'b1}));
      repeat (9) tick();
      check("ltsm_no_early_ack", 64'(o_ltsm_ack), 64'd0);
      tx_busy = 1'b0;
      tick();
      check("ltsm_ack", 64'({o_ltsm_ack, o_grant}), 64'({1'b1, 2'd0}));
      ltsm_req = 1'b0;
      tick();
      check("ltsm_ack_pulse", 64'(o_ltsm_ack), 64'd0);

      // busy already high in IDLE does not block a pattern grant
      do_reset();
      pat_req = 1'b1; tx_busy = 1'b1;
      tick();
      check("pat_busy_grant", 64'({o_grant, o_tx_pattern_req}), 64'({2'd1, 1'b1}));
      tick();
      check("pat_busy_handoff", 64'(o_tx_pattern_req), 64'd0);
      tx_busy = 1'b0;
      tick();
      check("pat_busy_ack", 64'(o_pat_ack), 64'd1);
      pat_req = 1'b0;

      // continuous LTSM + RDI requests alternate
      do_reset();
      ltsm_req = 1'b1; rdi_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (o_grant == 2'd0 && w < 8) begin
            tick();
            w++;
         end
         check($sformatf("rr_grant[%0d]", k), 64'(o_grant), (k % 2 == 1) ? 64'd3 : 64'd2);
         tx_busy = 1'b1;
         tick();
         tx_busy = 1'b0;
         tick();
         check($sformatf("rr_ack[%0d]", k), 64'({o_ltsm_ack, o_rdi_ack}), (k % 2 == 1) ? 64'd1 : 64'd2);
      end

      // reset in WAIT_DONE drops the transfer silently
      do_reset();
      ltsm_req = 1'b1;
      tick();
      tx_busy = 1'b1;
      tick();
      check("rst_mid_grant", 64'(o_grant), 64'd2);
      rst_n = 1'b0;
      tick();
      check("rst_mid_outputs", 64'(all_out), 64'd0);
      rst_n = 1'b1; tx_busy = 1'b0; ltsm_req = 1'b0;
      nerr = 0;
      repeat (3) begin
         tick();
         if (o_ltsm_ack || o_timeout || o_grant != 2'd0) nerr++;
      end
      check("rst_mid_no_ack", 64'(nerr), 64'd0);

      // RDI payload is frozen at grant
      do_reset();
      rdi_req = 1'b1; rdi_code = 2'b10; rdi_sub = 4'h9; rdi_info = 2'b01;
      tick();
      check("rdi_grant", 64'({o_grant, o_tx_rdi_msg, o_tx_data_valid, o_tx_rdi_code, o_tx_rdi_sub_code, o_tx_rdi_info}),
            64'({2'd3, 1'b1, 1'b0, 2'b10, 4'h9, 2'b01}));
      tx_busy = 1'b1;
      tick();
      rdi_code = 2'b01; rdi_sub = 4'h3; rdi_info = 2'b10;
      tick();
      check("rdi_frozen", 64'({o_tx_rdi_code, o_tx_rdi_sub_code, o_tx_rdi_info}), 64'({2'b10, 4'h9, 2'b01}));
      tx_busy = 1'b0;
      tick();
      check("rdi_ack", 64'(o_rdi_ack), 64'd1);
      rdi_req = 1'b0;
      tick();

      // busy stuck high
      do_reset();
      ltsm_req = 1'b1; tx_busy = 1'b1;
      tick();
      check("stuck_grant", 64'(o_grant), 64'd2);
      nerr = 0;
`ifdef SB_ARB_TIMEOUT_EN
      for (int i = 2; i < TMO + 1; i++) begin
         tick();
         if (o_timeout || o_grant != 2'd2) nerr++;
      end
      check("tmo_early", 64'(nerr), 64'd0);
      tick();
      check("tmo_pulse", 64'({o_timeout, o_grant, o_ltsm_ack, o_tx_msg_valid}), 64'({1'b1, 2'd0, 1'b0, 1'b0}));
      ltsm_req = 1'b0; tx_busy = 1'b0;
      tick();
      check("tmo_pulse_end", 64'({o_timeout, o_ltsm_ack}), 64'd0);
`else
      repeat (40) begin
         tick();
         if (o_timeout || o_grant != 2'd2) nerr++;
      end
      check("stuck_waits", 64'(nerr), 64'd0);
      tx_busy = 1'b0;
      tick();
      check("stuck_release_ack", 64'({o_ltsm_ack, o_timeout}), 64'({1'b1, 1'b0}));
      ltsm_req = 1'b0;
      tick();
`endif

      // randomized traffic against the transaction model
      do_reset();
      m_owner = 0; m_last = 3; m_ack = 0; m_age = 0;
      m_sent = 1'b0; m_tmo = 1'b0; m_dv = 1'b0; m_ltsm = '0; m_rdi = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (o_pat_ack) pat_req = 1'($urandom_range(0, 1));
         else if (!pat_req) pat_req = ($urandom_range(0, 7) == 0);
         else if ($urandom_range(0, 15) == 0) pat_req = 1'b0;
         if (o_ltsm_ack) ltsm_req = 1'($urandom_range(0, 1));
         else if (!ltsm_req) ltsm_req = ($urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 15) == 0) ltsm_req = 1'b0;
         if (o_rdi_ack) rdi_req = 1'($urandom_range(0, 1));
         else if (!rdi_req) rdi_req = ($urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 15) == 0) rdi_req = 1'b0;
         ltsm_msg_no = 4'($urandom); ltsm_msg_info = 3'($urandom); ltsm_data = 16'($urandom);
         ltsm_dv = 1'($urandom); rdi_code = 2'($urandom); rdi_sub = 4'($urandom); rdi_info = 2'($urandom);
         tx_busy = 1'($urandom);
         tick();
         model_edge();
         ctl_exp = {2'(m_owner), (m_owner == 1) && !m_sent, (m_owner >= 2) && !m_sent, m_owner == 3,
                    (m_owner == 2) && m_dv, m_ack == 1, m_ack == 2, m_ack == 3, m_tmo};
         check("rnd_ctl", 64'(ctl_obs), 64'(ctl_exp));
         if (m_owner == 2) check("rnd_ltsm_payload", 64'({o_tx_msg_no, o_tx_msg_info, o_tx_data}), 64'(m_ltsm));
         if (m_owner == 3) check("rnd_rdi_payload", 64'({o_tx_rdi_code, o_tx_rdi_sub_code, o_tx_rdi_info}), 64'(m_rdi));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
